mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 47 ++++
 rtl/mem_lane.sv | 56 +++++
 rtl/mem_stage.sv | 186 ++++++++++++++++++
 tb/tb_mem_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: opcodes, writeback
// source encoding, FSM state encoding and access-size decode helpers.
package mem_stage_pkg;

  // MIPS load/store opcodes
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  // memtoreg value marking a load
  localparam logic [1:0] MTR_LOAD = 2'b01;

  // Data memory handshake states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Access width
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Any opcode that is not a byte or halfword access is handled as a word.
  function automatic size_t op_size(input logic [5:0] op);
    size_t sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      default:              sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  // Loads that sign-extend the extracted lane
  function automatic logic op_signed(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Little-endian byte-lane steering: byte enables and replicated store data
// going out, lane extraction with sign/zero extension coming back, plus
// alignment checking. Purely combinational.
module mem_lane
  import mem_stage_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  a,
  input  logic [31:0] busB,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misalign
);

  size_t       w_size;
  logic        w_signed;
  logic [31:0] w_shifted;

  assign w_size    = op_size(op);
  assign w_signed  = op_signed(op);
  // Move the addressed lane down to bit 0 so extraction is size-only.
  assign w_shifted = rdata >> {a, 3'b000};

  // Steering and extension per access width
  always_comb begin
    be       = 4'b1111;
    wdata    = busB;
    ldata    = rdata;
    misalign = 1'b0;
    case (w_size)
      SZ_BYTE: begin
        be       = 4'b0001 << a;
        wdata    = {4{busB[7:0]}};
        ldata    = w_signed ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                            : {24'h000000, w_shifted[7:0]};
        misalign = 1'b0;
      end
      SZ_HALF: begin
        be       = 4'b0011 << a;
        wdata    = {2{busB[15:0]}};
        ldata    = w_signed ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                            : {16'h0000, w_shifted[15:0]};
        misalign = a[0];
      end
      default: begin
        be       = 4'b1111;
        wdata    = busB;
        ldata    = rdata;
        misalign = (a != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data memory requests for loads and stores,
// stalls the upstream pipeline until the memory acknowledges, raises
// address-error exceptions on misaligned accesses and registers the
// writeback bundle.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  // EX/MEM inputs
  input  logic [31:0] mem_result,
  input  logic [31:0] mem_busB,
  input  logic [5:0]  mem_op,
  input  logic        mem_memwr,
  input  logic [1:0]  mem_memtoreg,
  input  logic [4:0]  mem_rw,
  input  logic        mem_regWr,
  output logic        mem_stall,
  // Data memory port
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  // Writeback
  output logic [31:0] wb_result,
  output logic [31:0] wb_mdata,
  output logic [4:0]  wb_rw,
  output logic        wb_regWr,
  output logic [1:0]  wb_memtoreg,
  // Exceptions toward CP0
  output logic        mem_adel,
  output logic        mem_ades,
  output logic [31:0] mem_badvaddr
);

  state_t      r_state;

  // Instruction captured at request issue, used to retire it on ack
  logic [5:0]  r_op;
  logic [1:0]  r_a;
  logic [31:0] r_result;
  logic [4:0]  r_rw;
  logic        r_regwr;
  logic [1:0]  r_memtoreg;
  logic        r_load;

  logic        w_store;
  logic        w_load;
  logic        w_access;
  logic [5:0]  w_lane_op;
  logic [1:0]  w_lane_a;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;
  logic        w_misalign;

  // A store flag wins over a load encoding so one access is never both.
  assign w_store  = mem_memwr;
  assign w_load   = !mem_memwr && (mem_memtoreg == MTR_LOAD);
  assign w_access = w_store || w_load;

  // While waiting, extract with the captured opcode/offset so the result
  // does not depend on what the (held) upstream register presents.
  assign w_lane_op = (r_state == ST_WAIT) ? r_op : mem_op;
  assign w_lane_a  = (r_state == ST_WAIT) ? r_a  : mem_result[1:0];

  mem_lane u_lane (
    .op       (w_lane_op),
    .a        (w_lane_a),
    .busB     (mem_busB),
    .rdata    (dm_rdata),
    .be       (w_be),
    .wdata    (w_wdata),
    .ldata    (w_ldata),
    .misalign (w_misalign)
  );

  // Stall: aligned access about to issue, or outstanding request not yet acked
  always_comb begin
    mem_stall = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: mem_stall = w_access && !w_misalign;
        ST_WAIT: mem_stall = !dm_ack;
        default: mem_stall = 1'b0;
      endcase
    end
  end

  // Capture the instruction being issued so it can be retired on ack
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= 6'd0;
      r_a        <= 2'd0;
      r_result   <= 32'd0;
      r_rw       <= 5'd0;
      r_regwr    <= 1'b0;
      r_memtoreg <= 2'd0;
      r_load     <= 1'b0;
    end else if (r_state == ST_IDLE && w_access && !w_misalign) begin
      r_op       <= mem_op;
      r_a        <= mem_result[1:0];
      r_result   <= mem_result;
      r_rw       <= mem_rw;
      r_regwr    <= mem_regWr;
      r_memtoreg <= mem_memtoreg;
      r_load     <= w_load;
    end
  end

  // Handshake FSM with registered memory, writeback and exception outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= 32'd0;
      dm_be        <= 4'd0;
      dm_wdata     <= 32'd0;
      wb_result    <= 32'd0;
      wb_mdata     <= 32'd0;
      wb_rw        <= 5'd0;
      wb_regWr     <= 1'b0;
      wb_memtoreg  <= 2'd0;
      mem_adel     <= 1'b0;
      mem_ades     <= 1'b0;
      mem_badvaddr <= 32'd0;
    end else begin
      // Exception flags are single-cycle pulses
      mem_adel <= 1'b0;
      mem_ades <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // dm_ack is deliberately not looked at here
          if (w_access && !w_misalign) begin
            r_state  <= ST_WAIT;
            dm_req   <= 1'b1;
            dm_we    <= w_store;
            dm_addr  <= {mem_result[31:2], 2'b00};
            dm_be    <= w_be;
            dm_wdata <= w_wdata;
            wb_regWr <= 1'b0;
          end else if (w_access) begin
            // Misaligned: no request, squash the writeback, report to CP0
            mem_adel     <= w_load;
            mem_ades     <= w_store;
            mem_badvaddr <= mem_result;
            wb_result    <= mem_result;
            wb_mdata     <= 32'd0;
            wb_rw        <= mem_rw;
            wb_regWr     <= 1'b0;
            wb_memtoreg  <= mem_memtoreg;
          end else begin
            wb_result   <= mem_result;
            wb_mdata    <= 32'd0;
            wb_rw       <= mem_rw;
            wb_regWr    <= mem_regWr;
            wb_memtoreg <= mem_memtoreg;
          end
        end
        ST_WAIT: begin
          if (dm_ack) begin
            r_state     <= ST_IDLE;
            dm_req      <= 1'b0;
            wb_result   <= r_result;
            wb_mdata    <= r_load ? w_ldata : 32'd0;
            wb_rw       <= r_rw;
            wb_regWr    <= r_regwr;
            wb_memtoreg <= r_memtoreg;
          end else begin
            // Bubble into writeback while the request is outstanding
            wb_regWr <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          dm_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage. Expected writeback bundles are pushed
// to a scoreboard queue when an instruction is driven and popped when the
// stage retires it; memory-side signals are checked against a table.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_result, mem_busB;
  logic [5:0]  mem_op;
  logic        mem_memwr;
  logic [1:0]  mem_memtoreg;
  logic [4:0]  mem_rw;
  logic        mem_regWr;
  logic        mem_stall;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic [31:0] wb_result, wb_mdata;
  logic [4:0]  wb_rw;
  logic        wb_regWr;
  logic [1:0]  wb_memtoreg;
  logic        mem_adel, mem_ades;
  logic [31:0] mem_badvaddr;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .mem_result(mem_result), .mem_busB(mem_busB), .mem_op(mem_op),
    .mem_memwr(mem_memwr), .mem_memtoreg(mem_memtoreg), .mem_rw(mem_rw),
    .mem_regWr(mem_regWr), .mem_stall(mem_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_result(wb_result), .wb_mdata(wb_mdata), .wb_rw(wb_rw),
    .wb_regWr(wb_regWr), .wb_memtoreg(wb_memtoreg),
    .mem_adel(mem_adel), .mem_ades(mem_ades), .mem_badvaddr(mem_badvaddr)
  );

  // kind: 0 non-access, 1 aligned access, 2 misaligned access
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        memwr;
    logic [1:0]  mtr;
    logic [31:0] result;
    logic [31:0] busb;
    logic [4:0]  rw;
    logic        regwr;
    int          n_wait;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mdata;
    int          kind;
  } txn_t;

  typedef struct {
    logic [31:0] result;
    logic [31:0] mdata;
    logic [4:0]  rw;
    logic        regwr;
    logic [1:0]  mtr;
  } wb_t;

  wb_t  sb_q[$];
  txn_t tbl[12];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic txn_t mk(input string name, input logic [5:0] op, input logic memwr,
                              input logic [1:0] mtr, input logic [31:0] result,
                              input logic [31:0] busb, input logic [4:0] rw, input logic regwr,
                              input int n_wait, input logic [31:0] rdata, input logic [3:0] be,
                              input logic [31:0] wdata, input logic [31:0] mdata, input int kind);
    txn_t t;
    t.name = name; t.op = op; t.memwr = memwr; t.mtr = mtr; t.result = result;
    t.busb = busb; t.rw = rw; t.regwr = regwr; t.n_wait = n_wait; t.rdata = rdata;
    t.be = be; t.wdata = wdata; t.mdata = mdata; t.kind = kind;
    return t;
  endfunction

  task automatic drive_idle();
    mem_result = 32'd0; mem_busB = 32'd0; mem_op = 6'd0; mem_memwr = 1'b0;
    mem_memtoreg = 2'b00; mem_rw = 5'd0; mem_regWr = 1'b0;
  endtask

  task automatic pop_compare(input string name);
    wb_t e;
    if (sb_q.size() == 0) begin
      check_val({name, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val({name, "_wb_result"},   wb_result,   e.result);
      check_val({name, "_wb_mdata"},    wb_mdata,    e.mdata);
      check_val({name, "_wb_rw"},       wb_rw,       e.rw);
      check_val({name, "_wb_regWr"},    wb_regWr,    e.regwr);
      check_val({name, "_wb_memtoreg"}, wb_memtoreg, e.mtr);
    end
  endtask

  // Drive one instruction starting at a negedge, return at a negedge after it retires
  task automatic run_txn(input txn_t t);
    wb_t e;
    int  stall_cnt;
    mem_result = t.result; mem_busB = t.busb; mem_op = t.op; mem_memwr = t.memwr;
    mem_memtoreg = t.mtr; mem_rw = t.rw; mem_regWr = t.regwr;
    dm_ack = 1'b0; dm_rdata = 32'd0;
    #1;
    if (t.kind == 2) begin
      check_val({t.name, "_stall"}, mem_stall, 1'b0);
      @(posedge clk); @(negedge clk);
      check_val({t.name, "_dm_req"}, dm_req, 1'b0);
      check_val({t.name, "_adel"}, mem_adel, !t.memwr);
      check_val({t.name, "_ades"}, mem_ades, t.memwr);
      check_val({t.name, "_badvaddr"}, mem_badvaddr, t.result);
      check_val({t.name, "_wb_regWr"}, wb_regWr, 1'b0);
      drive_idle();
      @(posedge clk); @(negedge clk);
      check_val({t.name, "_exc_pulse"}, {mem_adel, mem_ades}, 2'b00);
      $display("txn %-10s misaligned addr=0x%08h adel=%0b ades=%0b", t.name, t.result, !t.memwr, t.memwr);
      return;
    end
    e.result = t.result; e.mdata = t.mdata; e.rw = t.rw; e.regwr = t.regwr; e.mtr = t.mtr;
    sb_q.push_back(e);
    if (t.kind == 0) begin
      check_val({t.name, "_stall"}, mem_stall, 1'b0);
      @(posedge clk); @(negedge clk);
      check_val({t.name, "_stall_after"}, mem_stall, 1'b0);
      check_val({t.name, "_dm_req"}, dm_req, 1'b0);
      pop_compare(t.name);
      $display("txn %-10s non-access result=0x%08h rw=%0d", t.name, t.result, t.rw);
      return;
    end
    stall_cnt = 0;
    if (mem_stall) stall_cnt++;
    check_val({t.name, "_issue_stall"}, mem_stall, 1'b1);
    @(posedge clk); @(negedge clk);
    check_val({t.name, "_dm_req"},  dm_req,  1'b1);
    check_val({t.name, "_dm_we"},   dm_we,   t.memwr);
    check_val({t.name, "_dm_addr"}, dm_addr, t.result & 32'hFFFF_FFFC);
    check_val({t.name, "_dm_be"},   dm_be,   t.be);
    if (t.memwr) check_val({t.name, "_dm_wdata"}, dm_wdata, t.wdata);
    check_val({t.name, "_bubble"}, wb_regWr, 1'b0);
    for (int w = 0; w < t.n_wait; w++) begin
      #1;
      if (mem_stall) stall_cnt++;
      @(posedge clk); @(negedge clk);
      check_val({t.name, "_hold_req"}, dm_req, 1'b1);
      check_val({t.name, "_hold_be"},  dm_be,  t.be);
      check_val({t.name, "_hold_bubble"}, wb_regWr, 1'b0);
    end
    dm_ack = 1'b1; dm_rdata = t.rdata;
    #1;
    if (mem_stall) stall_cnt++;
    check_val({t.name, "_ack_stall"}, mem_stall, 1'b0);
    @(posedge clk); @(negedge clk);
    dm_ack = 1'b0;
    check_val({t.name, "_req_drop"}, dm_req, 1'b0);
    check_val({t.name, "_stall_cycles"}, stall_cnt, t.n_wait + 1);
    pop_compare(t.name);
    $display("txn %-10s addr=0x%08h be=%04b waits=%0d stall_cycles=%0d mdata=0x%08h",
             t.name, t.result, dm_be, t.n_wait, stall_cnt, wb_mdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          name       op         we   mtr    result        busb          rw reg wt rdata         be       wdata         mdata        kind
    tbl[0]  = mk("sw",     6'b101011, 1, 2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 1, 32'h0,        4'b1111, 32'hDEAD_BEEF, 32'h0,        1);
    tbl[1]  = mk("lb",     6'b100000, 0, 2'b01, 32'h0000_0103, 32'h0,         5, 1, 3, 32'h8012_3456, 4'b1000, 32'h0,         32'hFFFF_FF80, 1);
    tbl[2]  = mk("lhu",    6'b100101, 0, 2'b01, 32'h0000_0202, 32'h0,         7, 1, 0, 32'hBEEF_1234, 4'b1100, 32'h0,         32'h0000_BEEF, 1);
    tbl[3]  = mk("lw_mis", 6'b100011, 0, 2'b01, 32'h0000_0101, 32'h0,         8, 1, 0, 32'h0,        4'b0000, 32'h0,         32'h0,        2);
    tbl[4]  = mk("sh_mis", 6'b101001, 1, 2'b00, 32'h0000_0101, 32'h1111_2222, 0, 0, 0, 32'h0,        4'b0000, 32'h0,         32'h0,        2);
    tbl[5]  = mk("add",    6'b000000, 0, 2'b00, 32'h0000_0055, 32'h0,         3, 1, 0, 32'h0,        4'b0000, 32'h0,         32'h0,        0);
    tbl[6]  = mk("sb",     6'b101000, 1, 2'b00, 32'h0000_0102, 32'h0000_00A5, 0, 0, 0, 32'h0,        4'b0100, 32'hA5A5_A5A5, 32'h0,        1);
    tbl[7]  = mk("sh",     6'b101001, 1, 2'b00, 32'h0000_0102, 32'h1234_CAFE, 0, 0, 2, 32'h0,        4'b1100, 32'hCAFE_CAFE, 32'h0,        1);
    tbl[8]  = mk("lh",     6'b100001, 0, 2'b01, 32'h0000_0100, 32'h0,         9, 1, 0, 32'h1234_8001, 4'b0011, 32'h0,         32'hFFFF_8001, 1);
    tbl[9]  = mk("lbu",    6'b100100, 0, 2'b01, 32'h0000_0101, 32'h0,        10, 1, 0, 32'h0000_9F00, 4'b0010, 32'h0,         32'h0000_009F, 1);
    tbl[10] = mk("lw",     6'b100011, 0, 2'b01, 32'h0000_0204, 32'h0,        11, 1, 1, 32'h1122_3344, 4'b1111, 32'h0,         32'h1122_3344, 1);
    tbl[11] = mk("op_unk", 6'b111111, 0, 2'b01, 32'h0000_0208, 32'h0,        12, 1, 0, 32'hCAFE_F00D, 4'b1111, 32'h0,         32'hCAFE_F00D, 1);

    // Reset with an access presented: stall must stay low, outputs clear
    rst = 1'b1; drive_idle(); mem_memwr = 1'b1; mem_op = 6'b101011;
    dm_ack = 1'b0; dm_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_stall", mem_stall, 1'b0);
    check_val("rst_dm", {dm_req, dm_we, dm_be}, 6'd0);
    check_val("rst_dm_addr", dm_addr, 32'd0);
    check_val("rst_dm_wdata", dm_wdata, 32'd0);
    check_val("rst_wb", {wb_rw, wb_regWr, wb_memtoreg}, 8'd0);
    check_val("rst_wb_result", wb_result, 32'd0);
    check_val("rst_wb_mdata", wb_mdata, 32'd0);
    check_val("rst_exc", {mem_adel, mem_ades}, 2'b00);
    check_val("rst_badvaddr", mem_badvaddr, 32'd0);
    $display("txn reset     outputs checked");
    rst = 1'b0; drive_idle();
    @(negedge clk);

    // Table runs back-to-back: each access is presented right after the previous retires
    for (int i = 0; i < 12; i++) run_txn(tbl[i]);

    // Reset while waiting, then a late ack that must be ignored
    mem_result = 32'h0000_0300; mem_op = 6'b100011; mem_memtoreg = 2'b01;
    mem_memwr = 1'b0; mem_rw = 5'd20; mem_regWr = 1'b1;
    @(posedge clk); @(negedge clk);
    check_val("rstw_req", dm_req, 1'b1);
    rst = 1'b1;
    #1;
    check_val("rstw_stall", mem_stall, 1'b0);
    @(posedge clk); @(negedge clk);
    check_val("rstw_req_clr", dm_req, 1'b0);
    check_val("rstw_be_clr", dm_be, 4'd0);
    rst = 1'b0; drive_idle(); dm_ack = 1'b1; dm_rdata = 32'h7777_7777;
    #1;
    check_val("rstw_late_stall", mem_stall, 1'b0);
    @(posedge clk); @(negedge clk);
    dm_ack = 1'b0;
    check_val("rstw_late_req", dm_req, 1'b0);
    check_val("rstw_late_regWr", wb_regWr, 1'b0);
    check_val("rstw_late_mdata", wb_mdata, 32'd0);
    $display("txn rst_wait  access abandoned, late ack ignored");
    run_txn(tbl[10]);

    drive_idle();
    check_val("sb_drain", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
